// File: rtl/ad7606_emu.sv
// AD7606 device emulator: the responder end of the AD7606 parallel interface.
// It answers CONVST/CS/RD/RESET with BUSY, FRSTDATA and up to NCH channel
// words on the 16-bit bus. All inputs come from the clk domain.
// Optional feature macro: AD7606_EMU_PATTERN_EN. When it is defined,
// ch_data_in is ignored and each channel word is generated as
// base + n*STEP, with base advancing by STEP per completed conversion.
module ad7606_emu #(
    parameter int          CONV_CYC = 200,
    parameter int          NCH      = 8,
    parameter logic [15:0] STEP     = 16'd257
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ad_convstab,
    input  logic              ad_cs,
    input  logic              ad_rd,
    input  logic              ad_reset,
    input  logic [2:0]        ad_os,
    input  logic [16*NCH-1:0] ch_data_in,
    output logic [15:0]       ad_data,
    output logic              ad_busy,
    output logic              first_data,
    output logic              conv_done
);

    localparam int PW = $clog2(NCH + 1);

    typedef enum logic [1:0] {IDLE, CONV, READ} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              convst_q;
    logic              rd_q;
    logic              convst_rise;
    logic              rd_fall;
    logic [2:0]        os_eff;
    logic [12:0]       conv_len;
    logic [12:0]       cnt;
    logic [PW-1:0]     ptr;
    logic [16*NCH-1:0] samples;
`ifdef AD7606_EMU_PATTERN_EN
    logic [15:0]       base;
`endif

    // Edge-detect registers; they keep tracking through ad_reset so that a
    // level held high across the device reset is not seen as a new edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            convst_q <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            convst_q <= ad_convstab;
            rd_q     <= ad_rd;
        end
    end

    assign convst_rise = ad_convstab & ~convst_q;
    assign rd_fall     = ~ad_rd & rd_q;
    // Oversampling code 7 is invalid on the real part; treat it as no oversampling.
    assign os_eff      = (ad_os == 3'd7) ? 3'd0 : ad_os;
    assign conv_len    = 13'((CONV_CYC << os_eff) - 1);

    // State register; device reset behaves like the system reset.
    always_ff @(posedge clk) begin
        if (!rst_n || ad_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: convst during CONV is ignored, convst wins over rd in READ.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (convst_rise) state_nxt = CONV;
            CONV:    if (cnt == 13'd0) state_nxt = READ;
            READ:    if (convst_rise) state_nxt = CONV;
            default: state_nxt = IDLE;
        endcase
    end

    // BUSY is high exactly while a conversion is counting down.
    always_comb begin
        ad_busy = (state == CONV);
    end

    // Conversion counter, sample latch and read-out register.
    always_ff @(posedge clk) begin
        if (!rst_n || ad_reset) begin
            ad_data    <= 16'h0000;
            first_data <= 1'b0;
            conv_done  <= 1'b0;
            ptr        <= '0;
            cnt        <= '0;
`ifdef AD7606_EMU_PATTERN_EN
            base       <= 16'h0000;
`endif
        end else begin
            conv_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (convst_rise) cnt <= conv_len;
                end
                CONV: begin
                    if (cnt == 13'd0) begin
`ifdef AD7606_EMU_PATTERN_EN
                        for (int n = 0; n < NCH; n++) begin
                            samples[16*n +: 16] <= base + 16'(n * int'(STEP));
                        end
                        base <= base + STEP;
`else
                        samples <= ch_data_in;
`endif
                        conv_done <= 1'b1;
                        ptr       <= '0;
                    end else begin
                        cnt <= cnt - 13'd1;
                    end
                end
                READ: begin
                    if (convst_rise) begin
                        cnt        <= conv_len;
                        ptr        <= '0;
                        first_data <= 1'b0;
                    end else if (rd_fall && !ad_cs) begin
                        if (ptr < PW'(NCH)) begin
                            ad_data    <= samples[16*ptr +: 16];
                            first_data <= (ptr == '0);
                            ptr        <= ptr + 1'b1;
                        end else begin
                            // Past the last channel: bus reads zero, pointer holds.
                            ad_data    <= 16'h0000;
                            first_data <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ad7606_emu.sv
// Directed testbench for ad7606_emu with a read-data scoreboard.
module tb_ad7606_emu;

    localparam int NCH = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ad_convstab;
    logic              ad_cs;
    logic              ad_rd;
    logic              ad_reset;
    logic [2:0]        ad_os;
    logic [16*NCH-1:0] ch_data_in;
    logic [15:0]       ad_data;
    logic              ad_busy;
    logic              first_data;
    logic              conv_done;

    int total = 0;
    int bad   = 0;
    logic [16:0] exp_q[$];

    ad7606_emu #(.CONV_CYC(200), .NCH(NCH), .STEP(16'd257)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ad_convstab (ad_convstab),
        .ad_cs       (ad_cs),
        .ad_rd       (ad_rd),
        .ad_reset    (ad_reset),
        .ad_os       (ad_os),
        .ch_data_in  (ch_data_in),
        .ad_data     (ad_data),
        .ad_busy     (ad_busy),
        .first_data  (first_data),
        .conv_done   (conv_done)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Start a conversion and count busy cycles; optionally pulse convst or
    // ad_reset at a given busy cycle.
    task automatic run_conv(input logic [2:0] os, input int restart_at, input int reset_at,
                            output int len, output int dones);
        ad_os       = os;
        ad_convstab = 1'b1;
        tick();
        ad_convstab = 1'b0;
        len   = 0;
        dones = 0;
        while (ad_busy && len < 20000) begin
            len++;
            ad_convstab = (len == restart_at);
            ad_reset    = (len == reset_at);
            tick();
            if (conv_done) dones++;
        end
        ad_convstab = 1'b0;
        ad_reset    = 1'b0;
    endtask

    task automatic rd_pulse(input logic cs);
        ad_cs = cs;
        ad_rd = 1'b0;
        tick();
        tick();
        ad_rd = 1'b1;
        tick();
        ad_cs = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [15:0] d, input logic f);
        logic [16:0] e;
        exp_q.push_back({f, d});
        rd_pulse(1'b0);
        e = exp_q.pop_front();
        check({tag, "_data"}, 32'(ad_data), 32'(e[15:0]));
        check({tag, "_first"}, 32'(first_data), 32'(e[16]));
    endtask

    initial begin
        int len;
        int dones;
        rst_n       = 1'b0;
        ad_convstab = 1'b0;
        ad_cs       = 1'b1;
        ad_rd       = 1'b1;
        ad_reset    = 1'b0;
        ad_os       = 3'd0;
        for (int i = 0; i < NCH; i++) ch_data_in[16*i +: 16] = 16'(16'h1111 * (i + 1));
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_data", 32'(ad_data), 32'h0);
        check("rst_busy", 32'(ad_busy), 32'h0);
        check("rst_first", 32'(first_data), 32'h0);
        check("rst_done", 32'(conv_done), 32'h0);

        // Basic conversion, os=0
        run_conv(3'd0, -1, -1, len, dones);
        check("os0_len", 32'(len), 32'd200);
        check("os0_done_at_fall", 32'(conv_done), 32'h1);
        check("os0_done_count", 32'(dones), 32'd1);
        tick();
        check("os0_done_pulse_end", 32'(conv_done), 32'h0);

`ifdef AD7606_EMU_PATTERN_EN
        for (int n = 0; n < NCH; n++) read_check("pat1", 16'(n * 257), n == 0);
        run_conv(3'd0, -1, -1, len, dones);
        check("pat2_len", 32'(len), 32'd200);
        for (int n = 0; n < NCH; n++) read_check("pat2", 16'((n + 1) * 257), n == 0);
`else
        for (int n = 0; n < NCH; n++) read_check("ch", 16'(16'h1111 * (n + 1)), n == 0);
        read_check("ch9", 16'h0000, 1'b0);
        read_check("ch10", 16'h0000, 1'b0);

        // Reads with cs high are ignored; later input changes do not leak in
        run_conv(3'd0, -1, -1, len, dones);
        read_check("r2_ch1", 16'h1111, 1'b1);
        read_check("r2_ch2", 16'h2222, 1'b0);
        rd_pulse(1'b1);
        rd_pulse(1'b1);
        check("cs_high_data", 32'(ad_data), 32'h2222);
        check("cs_high_first", 32'(first_data), 32'h0);
        for (int i = 0; i < NCH; i++) ch_data_in[16*i +: 16] = 16'hDEAD;
        read_check("r2_ch3_latched", 16'h3333, 1'b0);
`endif

        // Oversampling lengths
        run_conv(3'd3, -1, -1, len, dones);
        check("os3_len", 32'(len), 32'd1600);
        check("os3_done_count", 32'(dones), 32'd1);
        run_conv(3'd7, -1, -1, len, dones);
        check("os7_len", 32'(len), 32'd200);

        // Convst during CONV does not restart
        run_conv(3'd0, 50, -1, len, dones);
        check("restart_ignored_len", 32'(len), 32'd200);
        check("restart_ignored_done", 32'(dones), 32'd1);

        // Device reset mid-conversion aborts silently
        run_conv(3'd0, -1, 100, len, dones);
        check("reset_abort_len", 32'(len), 32'd100);
        check("reset_abort_dones", 32'(dones), 32'd0);
        check("reset_abort_busy", 32'(ad_busy), 32'h0);
        check("reset_abort_data", 32'(ad_data), 32'h0);
        tick();
        check("reset_abort_no_done", 32'(conv_done), 32'h0);

        // Reads in IDLE are ignored
        rd_pulse(1'b0);
        check("idle_rd_data", 32'(ad_data), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #5ms;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
